fir_tdm_mac: RTL and testbench

Parametrised, time-multiplexed FIR filter core for the equalizer band filters. It generalises the fixed 64-phase, counter-plus-phase-check filter skeleton to NTAPS phases and runtime-loadable coefficients. Each output sample is computed with a single serial multiply-accumulate (MAC) over NTAPS enabled cycles. One instance implements any band (LPF/BPF/HPF); the coefficient set selects which.

---
 rtl/fir_tdm_mac.sv | 134 +++++++++++++
 tb/tb_fir_tdm_mac.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tdm_mac.sv
// fir_tdm_mac: time-multiplexed FIR core. One serial MAC walks NTAPS phases
// per output sample; coefficients are runtime-writable registers.
module fir_tdm_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 64,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(NTAPS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_enable,
    input  logic signed [DATA_W-1:0]  filter_in,
    input  logic                      coef_we,
    input  logic [$clog2(NTAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic signed [DATA_W-1:0]  filter_out,
    output logic                      ce_out,
    output logic                      phase_first,
    output logic                      phase_last
);

    localparam int CW = $clog2(NTAPS);
    localparam int PW = DATA_W + COEF_W;
    localparam logic [CW-1:0] LAST   = CW'(NTAPS - 1);
    localparam logic [CW:0]   NT_EXT = (CW+1)'(NTAPS);
    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(64'sd1 <<< (COEF_W - 2));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

    logic [CW-1:0]             count;
    logic [CW-1:0]             wp;
    logic signed [DATA_W-1:0]  dline [NTAPS];
    logic signed [COEF_W-1:0]  coef  [NTAPS];
    logic signed [ACC_W-1:0]   acc;

    logic [CW:0]               idx_sum;
    logic [CW:0]               idx_wrap;
    logic [CW-1:0]             rd_idx;
    logic signed [DATA_W-1:0]  x_sel;
    logic signed [COEF_W-1:0]  h_sel;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W:0]     rnd;
    logic signed [ACC_W:0]     shr;
    logic signed [DATA_W-1:0]  sat;

    assign phase_first = clk_enable && (count == '0);
    assign phase_last  = clk_enable && (count == LAST);

    // Delay-line read address (wp + count) mod NTAPS, valid for non-power-of-2 NTAPS
    always_comb begin
        idx_sum  = {1'b0, wp} + {1'b0, count};
        idx_wrap = idx_sum;
        if (idx_sum >= NT_EXT)
            idx_wrap = idx_sum - NT_EXT;
        rd_idx = idx_wrap[CW-1:0];
    end

    // MAC datapath: phase 0 bypasses the delay line and restarts the sum
    always_comb begin
        x_sel = (count == '0) ? filter_in : dline[rd_idx];
        h_sel = coef[count];
        prod  = PW'(x_sel) * PW'(h_sel);
        sum   = ((count == '0) ? '0 : acc) + ACC_W'(prod);
    end

    // Round half up, arithmetic shift back to sample scale, then clamp
    always_comb begin
        rnd = (ACC_W+1)'(sum) + HALF;
        shr = rnd >>> (COEF_W - 1);
        sat = DATA_W'(shr);
        if (shr > SAT_MAX)
            sat = DATA_W'(SAT_MAX);
        else if (shr < SAT_MIN)
            sat = DATA_W'(SAT_MIN);
    end

    // Phase counter, wraps at NTAPS-1, holds when gated
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clk_enable)
            count <= (count == LAST) ? '0 : count + 1'b1;
    end

    // Write pointer steps back one slot per frame so reads see x[n-k] at wp+k
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wp <= '0;
        else if (phase_last)
            wp <= (wp == '0) ? LAST : wp - 1'b1;
    end

    // Capture the new sample into the circular history at frame start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++)
                dline[i] <= '0;
        end else if (phase_first) begin
            dline[wp] <= filter_in;
        end
    end

    // Coefficient writes ignore clk_enable; same-edge reads see the old value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NTAPS; i++)
                coef[i] <= '0;
        end else if (coef_we && (coef_addr <= LAST)) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Accumulator advances once per enabled phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (clk_enable)
            acc <= sum;
    end

    // Output register and single-cycle update strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filter_out <= '0;
            ce_out     <= 1'b0;
        end else begin
            ce_out <= phase_last;
            if (phase_last)
                filter_out <= sat;
        end
    end

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Directed bench for fir_tdm_mac with NTAPS=4, 16-bit samples and coefficients.
module tb_fir_tdm_mac;

    logic               clk;
    logic               rst;
    logic               clk_enable;
    logic signed [15:0] filter_in;
    logic               coef_we;
    logic [1:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic signed [15:0] filter_out;
    logic               ce_out;
    logic               phase_first;
    logic               phase_last;

    int checks;
    int failures;

    fir_tdm_mac #(.DATA_W(16), .COEF_W(16), .NTAPS(4)) dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .filter_in(filter_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .filter_out(filter_out), .ce_out(ce_out),
        .phase_first(phase_first), .phase_last(phase_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0; clk_enable = 1'b0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; filter_in = '0;
        step(); step();
        rst = 1'b1;
    endtask

    task automatic load_coefs(input logic signed [15:0] c0, input logic signed [15:0] c1,
                              input logic signed [15:0] c2, input logic signed [15:0] c3);
        logic signed [15:0] c [4];
        c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
        clk_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            coef_we = 1'b1; coef_addr = 2'(i); coef_data = c[i];
            step();
        end
        coef_we = 1'b0;
    endtask

    // One ungated frame; reports output, strobe, early strobes and phase-flag errors
    task automatic run_frame(input logic signed [15:0] s, output logic signed [15:0] y,
                             output logic ce_end, output int bad);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            filter_in = (i == 0) ? s : 16'sh5a5a;
            clk_enable = 1'b1;
            #1;
            if (phase_first !== (i == 0) || phase_last !== (i == 3)) bad++;
            step();
            if (i < 3 && ce_out !== 1'b0) bad++;
        end
        y = filter_out;
        ce_end = ce_out;
        clk_enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_enable = 1'b1; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; filter_in = 16'sd123;
        #2 rst = 1'b0;
        #1;
        checks++; if (filter_out !== 16'sd0) begin failures++; $display("FAIL reset_out got=%0d exp=0", filter_out); end
        checks++; if (ce_out !== 1'b0) begin failures++; $display("FAIL reset_ce got=%b exp=0", ce_out); end
        checks++; if (phase_first !== 1'b1) begin failures++; $display("FAIL reset_pf_en got=%b exp=1", phase_first); end
        checks++; if (phase_last !== 1'b0) begin failures++; $display("FAIL reset_pl got=%b exp=0", phase_last); end
        clk_enable = 1'b0;
        #1;
        checks++; if (phase_first !== 1'b0) begin failures++; $display("FAIL reset_pf_dis got=%b exp=0", phase_first); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_impulse();
        logic signed [15:0] ins [6] = '{16'sd1000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        logic signed [15:0] exp [6] = '{16'sd500, 16'sd250, -16'sd250, 16'sd125, 16'sd0, 16'sd0};
        logic signed [15:0] y;
        logic ce;
        int bad;
        apply_reset();
        load_coefs(16'sd16384, 16'sd8192, -16'sd8192, 16'sd4096);
        for (int f = 0; f < 6; f++) begin
            run_frame(ins[f], y, ce, bad);
            checks++; if (y !== exp[f]) begin failures++; $display("FAIL impulse_out f%0d got=%0d exp=%0d", f, y, exp[f]); end
            checks++; if (ce !== 1'b1 || bad != 0) begin failures++; $display("FAIL impulse_ce f%0d ce=%b phase_errs=%0d exp ce=1 errs=0", f, ce, bad); end
        end
    endtask

    task automatic test_saturation();
        logic signed [15:0] y;
        logic ce;
        int bad;
        apply_reset();
        load_coefs(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
        for (int f = 0; f < 5; f++) begin
            run_frame(16'sd32767, y, ce, bad);
            if (f >= 3) begin
                checks++; if (y !== 16'sd32767) begin failures++; $display("FAIL sat_pos f%0d got=%0d exp=32767", f, y); end
            end
        end
        for (int f = 0; f < 4; f++) run_frame(-16'sd32768, y, ce, bad);
        checks++; if (y !== -16'sd32768) begin failures++; $display("FAIL sat_neg got=%0d exp=-32768", y); end
    endtask

    task automatic test_rounding();
        logic signed [15:0] ins [4] = '{16'sd16384, 16'sd16383, -16'sd16384, -16'sd16385};
        logic signed [15:0] exp [4] = '{16'sd1, 16'sd0, 16'sd0, -16'sd1};
        logic signed [15:0] y;
        logic ce;
        int bad;
        apply_reset();
        load_coefs(16'sd1, 16'sd0, 16'sd0, 16'sd0);
        for (int f = 0; f < 4; f++) begin
            run_frame(ins[f], y, ce, bad);
            checks++; if (y !== exp[f]) begin failures++; $display("FAIL round in=%0d got=%0d exp=%0d", ins[f], y, exp[f]); end
        end
    endtask

    task automatic test_gating();
        logic signed [15:0] ins [6] = '{16'sd1000, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        logic signed [15:0] exp [6] = '{16'sd500, 16'sd250, -16'sd250, 16'sd125, 16'sd0, 16'sd0};
        int pulses, extra, done, cyc;
        logic en;
        apply_reset();
        load_coefs(16'sd16384, 16'sd8192, -16'sd8192, 16'sd4096);
        pulses = 0; extra = 0;
        for (int f = 0; f < 6; f++) begin
            done = 0; cyc = 0;
            while (done < 4 && cyc < 1000) begin
                en = ($urandom_range(0, 9) < 3);
                filter_in = (done == 0) ? ins[f] : 16'sh5a5a;
                clk_enable = en;
                step();
                cyc++;
                if (en) done++;
                if (ce_out === 1'b1) begin
                    pulses++;
                    if (done < 4) extra++;
                end
            end
            checks++; if (done != 4) begin failures++; $display("FAIL gate_timeout f%0d edges=%0d exp=4", f, done); end
            checks++; if (filter_out !== exp[f] || ce_out !== 1'b1) begin failures++; $display("FAIL gate_out f%0d got=%0d ce=%b exp=%0d ce=1", f, filter_out, ce_out, exp[f]); end
            clk_enable = 1'b0;
            step();
            checks++; if (ce_out !== 1'b0) begin failures++; $display("FAIL gate_pulse_width f%0d got=%b exp=0", f, ce_out); end
        end
        checks++; if (pulses != 6 || extra != 0) begin failures++; $display("FAIL gate_pulse_count got=%0d extra=%0d exp=6 extra=0", pulses, extra); end
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] ins [5] = '{16'sd1000, 16'sd0, 16'sd0, 16'sd0, 16'sd2000};
        logic signed [15:0] y;
        logic ce;
        int bad;
        apply_reset();
        load_coefs(16'sd16384, 16'sd8192, -16'sd8192, 16'sd4096);
        for (int f = 0; f < 5; f++) run_frame(ins[f], y, ce, bad);
        checks++; if (y !== 16'sd1000) begin failures++; $display("FAIL rstmid_pre got=%0d exp=1000", y); end
        filter_in = 16'sd0; clk_enable = 1'b1;
        step(); step();
        rst = 1'b0; clk_enable = 1'b0;
        #1;
        checks++; if (filter_out !== 16'sd0 || ce_out !== 1'b0) begin failures++; $display("FAIL rstmid_clear got=%0d ce=%b exp=0 ce=0", filter_out, ce_out); end
        step();
        rst = 1'b1;
        load_coefs(16'sd16384, 16'sd8192, -16'sd8192, 16'sd4096);
        run_frame(16'sd0, y, ce, bad);
        checks++; if (y !== 16'sd0 || ce !== 1'b1 || bad != 0) begin failures++; $display("FAIL rstmid_f0 got=%0d ce=%b errs=%0d exp=0 ce=1 errs=0", y, ce, bad); end
        run_frame(16'sd0, y, ce, bad);
        checks++; if (y !== 16'sd0 || ce !== 1'b1) begin failures++; $display("FAIL rstmid_f1 got=%0d ce=%b exp=0 ce=1", y, ce); end
    endtask

    task automatic test_live_coef();
        logic signed [15:0] ins [3] = '{16'sd1000, 16'sd0, 16'sd0};
        logic signed [15:0] exp [3] = '{16'sd500, 16'sd250, -16'sd250};
        logic signed [15:0] fin [3] = '{16'sd0, 16'sd1000, 16'sd1000};
        logic [1:0]         waddr [3] = '{2'd3, 2'd0, 2'd3};
        logic               wen [3] = '{1'b1, 1'b1, 1'b0};
        logic signed [15:0] fexp [3] = '{16'sd0, 16'sd500, 16'sd250};
        logic signed [15:0] y;
        logic ce;
        int bad;
        apply_reset();
        load_coefs(16'sd16384, 16'sd8192, -16'sd8192, 16'sd4096);
        for (int f = 0; f < 3; f++) begin
            run_frame(ins[f], y, ce, bad);
            checks++; if (y !== exp[f]) begin failures++; $display("FAIL live_pre f%0d got=%0d exp=%0d", f, y, exp[f]); end
        end
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) begin
                filter_in = (i == 0) ? fin[f] : 16'sh5a5a;
                clk_enable = 1'b1;
                coef_we = (i == 1) && wen[f];
                coef_addr = waddr[f];
                coef_data = 16'sd0;
                step();
            end
            coef_we = 1'b0; clk_enable = 1'b0;
            checks++; if (filter_out !== fexp[f]) begin failures++; $display("FAIL live_upd f%0d got=%0d exp=%0d", f, filter_out, fexp[f]); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_impulse();
        test_saturation();
        test_rounding();
        test_gating();
        test_reset_mid();
        test_live_coef();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
